minute_hour: RTL and testbench
==============================

MINUTE_HOUR -- requirements
Module: minute_hour

Interface
REQ-001 Parameter H24, default 1: 1 selects a 00-23 hour range, 0 selects a 12-hour range of 01-12.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 min_tick  input  1  one-cycle pulse from the upstream seconds stage, meaning one minute has elapsed.
REQ-005 btn_mode  input  1  one-cycle debounced pulse that advances the set-mode FSM.
REQ-006 btn_inc  input  1  one-cycle debounced pulse that increments the field currently being set.
REQ-007 min_10  output  4  BCD tens of minutes, range 0-5.
REQ-008 min1  output  4  BCD units of minutes, range 0-9.
REQ-009 hour_10  output  4  BCD tens of hours, range 0-2 (H24=1) or 0-1 (H24=0).
REQ-010 hour1  output  4  BCD units of hours.
REQ-011 day_out  output  1  one-cycle pulse on the day rollover.
REQ-012 set_hour, set_min  output  1 each  high while the FSM is in SET_HOUR or SET_MIN respectively.

Function
REQ-013 FSM states: RUN, SET_HOUR, SET_MIN.
REQ-014 FSM transitions occur only on btn_mode: RUN->SET_HOUR->SET_MIN->RUN.
REQ-015 RUN, minutes: each min_tick increments the minute count, and the new value is visible the cycle after the sampling edge.
REQ-016 RUN, minute carry: min1 wraps 9->0 and increments min_10; min_10:min1 wraps 59->00 and carries +1 to the hour in the same edge.
REQ-017 Hour sequence, H24=1: 09->10, 19->20, 23->00.
REQ-018 Hour sequence, H24=0: 09->10, 12->01.
REQ-019 day_out is registered and pulses in the same cycle the outputs show 00:00 (H24=1) or 01:00 (H24=0, on 12:59->01:00).
REQ-020 day_out stays low at every other time, including in the set states.
REQ-021 SET_HOUR: btn_inc increments the hour with the same wrap as REQ-017/018; minutes are not affected and day_out does not pulse.
REQ-022 SET_MIN: btn_inc increments the minute 59->00 with no carry into the hour.
REQ-023 In SET_HOUR and SET_MIN, min_tick is discarded; time is frozen and lost ticks are not recovered.
REQ-024 min_tick and btn_mode in the same RUN cycle: the tick is applied and the state moves to SET_HOUR on the same edge.
REQ-025 btn_inc and btn_mode in the same set-state cycle: the increment applies to the current field, then the state advances.
REQ-026 btn_inc in RUN is ignored.
REQ-027 All digit registers hold legal BCD at all times; no illegal value is reachable from reset.
REQ-028 All outputs are registered; there is no combinational path from input to output.

Reset
REQ-029 When rst=1 at a clk edge: state=RUN, set_hour=0, set_min=0, day_out=0, minutes=00.
REQ-030 Hour reset value is 00 for H24=1 and 12 for H24=0.
REQ-031 rst has priority over every other input in the same cycle.
REQ-032 rst in a set state aborts the edit and returns to RUN with the reset values.

Structure
REQ-033 Shared package watch_pkg holds the FSM state typedef (mh_state_t) plus the BCD limit constants (MIN_TENS_MAX=5, DIGIT_MAX=9, H24_MAX=23, H12_MIN=1, H12_MAX=12).
REQ-034 One sub-module, bcd_mod_counter, implements the two-digit BCD counter with enable and a carry/wrap output.
REQ-035 bcd_mod_counter is instantiated once for minutes; hours use a separate instance or dedicated logic for the H24=0 range.
REQ-036 Expected RTL size is 150-300 lines total.

Verification
REQ-037 Reset, then 61 min_tick pulses -> display 01:01 (H24=1); day_out never asserted.
REQ-038 Preload 23:59 via set mode, return to RUN, one min_tick -> next cycle shows 00:00 and day_out=1 for exactly one cycle.
REQ-039 H24=0: reset shows 12:00; 59 ticks then 1 tick -> 12:59 then 01:00 with a day_out pulse; set hour 12, btn_inc -> 01.
REQ-040 SET_MIN at 59, btn_inc -> 00 with hour unchanged; min_tick pulses in the set states leave the time unchanged.
REQ-041 Same-cycle min_tick+btn_mode in RUN at 10:15 -> 10:16 and set_hour=1.
REQ-042 rst asserted mid SET_MIN -> next cycle RUN, set_min=0, time at reset value.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and BCD limits for the watch time-keeping blocks.
package watch_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } mh_state_t;

   localparam int unsigned MIN_TENS_MAX = 32'd5;
   localparam int unsigned DIGIT_MAX    = 32'd9;
   localparam int unsigned H24_MAX      = 32'd23;
   localparam int unsigned H12_MIN      = 32'd1;
   localparam int unsigned H12_MAX      = 32'd12;

   function automatic logic [3:0] bcd_tens(input int unsigned v);
      return 4'(v / 32'd10);
   endfunction

   function automatic logic [3:0] bcd_units(input int unsigned v);
      return 4'(v % 32'd10);
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter: counts up on en, reloads the wrap value after the
// maximum, and flags the wrap in the same cycle so a higher stage can follow.
module bcd_mod_counter
   import watch_pkg::*;
#(
   parameter logic [3:0] MAX_TENS   = 4'd5,
   parameter logic [3:0] MAX_UNITS  = 4'd9,
   parameter logic [3:0] WRAP_TENS  = 4'd0,
   parameter logic [3:0] WRAP_UNITS = 4'd0,
   parameter logic [3:0] RST_TENS   = 4'd0,
   parameter logic [3:0] RST_UNITS  = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [3:0] tens_o,
   output logic [3:0] units_o,
   output logic       wrap_o
);

   localparam logic [3:0] UNIT_TOP = bcd_units(DIGIT_MAX);

   logic [3:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic       at_max_s;

   assign at_max_s = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
   assign wrap_o   = en & at_max_s;
   assign tens_o   = tens_q;
   assign units_o  = units_q;

   // Next count: wrap reload, units carry into tens, or plain units increment.
   always_comb begin
      tens_d  = tens_q;
      units_d = units_q;
      if (!en) begin
         tens_d  = tens_q;
         units_d = units_q;
      end else if (at_max_s) begin
         tens_d  = WRAP_TENS;
         units_d = WRAP_UNITS;
      end else if (units_q == UNIT_TOP) begin
         tens_d  = tens_q + 4'd1;
         units_d = 4'd0;
      end else begin
         units_d = units_q + 4'd1;
      end
   end

   // Digit registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tens_q  <= RST_TENS;
         units_q <= RST_UNITS;
      end else begin
         tens_q  <= tens_d;
         units_q <= units_d;
      end
   end

endmodule

// File: rtl/minute_hour.sv
// Minutes/hours stage of the watch: counts min_tick pulses in RUN and lets the
// user set hour then minute through a btn_mode / btn_inc set-mode FSM.
module minute_hour
   import watch_pkg::*;
#(
   parameter bit H24 = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       min_tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [3:0] min_10,
   output logic [3:0] min1,
   output logic [3:0] hour_10,
   output logic [3:0] hour1,
   output logic       day_out,
   output logic       set_hour,
   output logic       set_min
);

   // The 12-hour range runs 01..12, so it wraps to 01 and resets to 12.
   localparam int unsigned HOUR_MAX  = H24 ? H24_MAX : H12_MAX;
   localparam int unsigned HOUR_WRAP = H24 ? 32'd0   : H12_MIN;
   localparam int unsigned HOUR_RST  = H24 ? 32'd0   : H12_MAX;

   mh_state_t state_q, state_d;
   logic      set_hour_q, set_min_q, day_q, day_d;
   logic      run_s, in_set_hour_s, in_set_min_s;
   logic      min_en_s, min_wrap_s, hour_en_s, hour_wrap_s;

   assign run_s         = (state_q == RUN);
   assign in_set_hour_s = (state_q == SET_HOUR);
   assign in_set_min_s  = (state_q == SET_MIN);

   // Set-state increments never carry; only a running minute wrap moves the hour.
   assign min_en_s  = (run_s & min_tick) | (in_set_min_s & btn_inc);
   assign hour_en_s = (run_s & min_wrap_s) | (in_set_hour_s & btn_inc);

   bcd_mod_counter #(
      .MAX_TENS   (bcd_tens(MIN_TENS_MAX * 32'd10)),
      .MAX_UNITS  (bcd_units(DIGIT_MAX)),
      .WRAP_TENS  (4'd0),
      .WRAP_UNITS (4'd0),
      .RST_TENS   (4'd0),
      .RST_UNITS  (4'd0)
   ) u_min (
      .clk     (clk),
      .rst     (rst),
      .en      (min_en_s),
      .tens_o  (min_10),
      .units_o (min1),
      .wrap_o  (min_wrap_s)
   );

   bcd_mod_counter #(
      .MAX_TENS   (bcd_tens(HOUR_MAX)),
      .MAX_UNITS  (bcd_units(HOUR_MAX)),
      .WRAP_TENS  (bcd_tens(HOUR_WRAP)),
      .WRAP_UNITS (bcd_units(HOUR_WRAP)),
      .RST_TENS   (bcd_tens(HOUR_RST)),
      .RST_UNITS  (bcd_units(HOUR_RST))
   ) u_hour (
      .clk     (clk),
      .rst     (rst),
      .en      (hour_en_s),
      .tens_o  (hour_10),
      .units_o (hour1),
      .wrap_o  (hour_wrap_s)
   );

   // Set-mode sequencing: only btn_mode moves the state.
   always_comb begin
      state_d = state_q;
      day_d   = run_s & hour_wrap_s;
      case (state_q)
         RUN:      if (btn_mode) state_d = SET_HOUR; else state_d = RUN;
         SET_HOUR: if (btn_mode) state_d = SET_MIN;  else state_d = SET_HOUR;
         SET_MIN:  if (btn_mode) state_d = RUN;      else state_d = SET_MIN;
         default:  state_d = RUN;
      endcase
   end

   // State and registered flag outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         set_hour_q <= 1'b0;
         set_min_q  <= 1'b0;
         day_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         set_hour_q <= (state_d == SET_HOUR);
         set_min_q  <= (state_d == SET_MIN);
         day_q      <= day_d;
      end
   end

   assign set_hour = set_hour_q;
   assign set_min  = set_min_q;
   assign day_out  = day_q;

endmodule

// File: tb/tb_minute_hour.sv
// Scoreboard bench: one 24-hour and one 12-hour DUT share stimulus; a
// minutes-of-day reference model queues expected outputs, a monitor compares.
module tb_minute_hour;

   logic clk = 1'b0;
   logic rst = 1'b1, min_tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
   logic [3:0] m10_a, m1_a, h10_a, h1_a, m10_b, m1_b, h10_b, h1_b;
   logic       day_a, sh_a, sm_a, day_b, sh_b, sm_b;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   typedef struct {
      int hr;
      int mn;
      int mode;
      bit day;
   } mstate_t;

   mstate_t m24, m12;
   logic [18:0] q24[$];
   logic [18:0] q12[$];

   always #5 clk = ~clk;

   minute_hour #(.H24(1'b1)) dut24 (
      .clk(clk), .rst(rst), .min_tick(min_tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .min_10(m10_a), .min1(m1_a), .hour_10(h10_a), .hour1(h1_a),
      .day_out(day_a), .set_hour(sh_a), .set_min(sm_a)
   );

   minute_hour #(.H24(1'b0)) dut12 (
      .clk(clk), .rst(rst), .min_tick(min_tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .min_10(m10_b), .min1(m1_b), .hour_10(h10_b), .hour1(h1_b),
      .day_out(day_b), .set_hour(sh_b), .set_min(sm_b)
   );

   function automatic int next_hour(input int hr, input bit h24);
      if (h24) return (hr + 1) % 24;
      return (hr % 12) + 1;
   endfunction

   function automatic mstate_t step(input mstate_t s, input bit h24,
                                    input bit r, input bit t, input bit b, input bit i);
      mstate_t n = s;
      n.day = 1'b0;
      if (r) begin
         n.mode = 0;
         n.mn   = 0;
         n.hr   = h24 ? 0 : 12;
      end else if (s.mode == 0) begin
         if (t) begin
            n.mn = s.mn + 1;
            if (n.mn == 60) begin
               n.mn  = 0;
               n.hr  = next_hour(s.hr, h24);
               n.day = h24 ? (n.hr == 0) : (n.hr == 1);
            end
         end
         if (b) n.mode = 1;
      end else if (s.mode == 1) begin
         if (i) n.hr = next_hour(s.hr, h24);
         if (b) n.mode = 2;
      end else begin
         if (i) n.mn = (s.mn + 1) % 60;
         if (b) n.mode = 0;
      end
      return n;
   endfunction

   function automatic logic [18:0] pack(input mstate_t s);
      return {4'(s.mn / 10), 4'(s.mn % 10), 4'(s.hr / 10), 4'(s.hr % 10),
              s.day, (s.mode == 1), (s.mode == 2)};
   endfunction

   task automatic cyc(input bit r, input bit t, input bit b, input bit i);
      @(negedge clk);
      rst = r; min_tick = t; btn_mode = b; btn_inc = i;
      m24 = step(m24, 1'b1, r, t, b, i);
      m12 = step(m12, 1'b0, r, t, b, i);
      q24.push_back(pack(m24));
      q12.push_back(pack(m12));
   endtask

   // From RUN: set the 24-hour DUT's time to hh:mm and return to RUN.
   task automatic set_time24(input int hh, input int mm);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 24 && m24.hr != hh; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 60 && m24.mn != mm; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   // Monitor: every cycle the DUTs present a full output word.
   initial begin
      logic [18:0] exp_v, got_v;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (q24.size() > 0) begin
            exp_v = q24.pop_front();
            got_v = {m10_a, m1_a, h10_a, h1_a, day_a, sh_a, sm_a};
            checks++;
            if (got_v !== exp_v) begin
               failures++;
               $display("FAIL h24_outputs cyc=%0d got=%h exp=%h", cycle, got_v, exp_v);
            end
         end
         if (q12.size() > 0) begin
            exp_v = q12.pop_front();
            got_v = {m10_b, m1_b, h10_b, h1_b, day_b, sh_b, sm_b};
            checks++;
            if (got_v !== exp_v) begin
               failures++;
               $display("FAIL h12_outputs cyc=%0d got=%h exp=%h", cycle, got_v, exp_v);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      m24 = '{hr: 0, mn: 0, mode: 0, day: 1'b0};
      m12 = '{hr: 12, mn: 0, mode: 0, day: 1'b0};

      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      // 61 minutes from reset.
      repeat (61) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      // Day rollover from 23:59.
      set_time24(23, 59);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      // Ticks discarded in set states; SET_MIN 59 -> 00 without hour carry.
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 60 && m24.mn != 59; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      // Tick and mode together at 10:15, then inc+mode in each set state.
      set_time24(10, 15);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      // Reset in the middle of SET_MIN.
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      // 12-hour rollover 12:59 -> 01:00, then set hour 12 -> 01.
      repeat (59) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 12 && m12.hr != 12; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      // Random traffic with occasional reset.
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q24.size() != 0 || q12.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d/%0d pending exp=0", q24.size(), q12.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
